// File: rtl/serial_compliment2_if.sv
// Handshake and result bundle for the bit-serial two's-complement negator.
// The master drives the operand and start request. The slave returns the serial stream and the parallel result.
interface serial_compliment2_if #(
    parameter int WIDTH = 4
);
    logic             start;
    logic [WIDTH-1:0] A;
    logic             busy;
    logic             ser_out;
    logic             ser_valid;
    logic             done;
    logic [WIDTH-1:0] OUT;
    logic             ovf;
    logic             zero;

    modport master (
        output start, A,
        input  busy, ser_out, ser_valid, done, OUT, ovf, zero
    );

    modport slave (
        input  start, A,
        output busy, ser_out, ser_valid, done, OUT, ovf, zero
    );
endinterface

// File: rtl/serial_compliment2.sv
// Bit-serial two's-complement negator. Bits are processed LSB first.
// Bits up to and including the first 1 are copied, and every later bit is inverted.
module serial_compliment2 #(
    parameter int WIDTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    serial_compliment2_if.slave  bus
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COPY   = 2'd1,
        INVERT = 2'd2,
        DONE   = 2'd3
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] sr;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] out_q;
    logic [CNT_W-1:0] cnt;
    logic             msb_in;
    logic             ovf_q;
    logic             zero_q;

    logic             processing;
    logic             res_bit;
    logic [WIDTH-1:0] res_next;

    // NOTE: every variable gets a default at the top, so no path leaves a latch.
    always_comb begin
        processing = 1'b0;
        res_bit    = 1'b0;
        res_next   = res;
        processing = (state == COPY) || (state == INVERT);
        res_bit    = sr[0] ^ (state == INVERT);
        res_next   = {res_bit, res[WIDTH-1:1]};
    end

    // The serial output is gated so it reads 0 whenever no bit is being produced.
    assign bus.busy      = processing;
    assign bus.ser_valid = processing;
    assign bus.ser_out   = processing & res_bit;
    assign bus.done      = (state == DONE);
    assign bus.OUT       = out_q;
    assign bus.ovf       = ovf_q;
    assign bus.zero      = zero_q;

    // NOTE: state is written with <= only, so every register samples the pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            sr     <= '0;
            res    <= '0;
            out_q  <= '0;
            cnt    <= '0;
            msb_in <= 1'b0;
            ovf_q  <= 1'b0;
            zero_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (bus.start) begin
                        sr     <= bus.A;
                        msb_in <= bus.A[WIDTH-1];
                        cnt    <= '0;
                        ovf_q  <= 1'b0;
                        zero_q <= 1'b0;
                        state  <= COPY;
                    end else begin
                        state  <= IDLE;
                    end
                end

                COPY, INVERT: begin
                    res <= res_next;
                    sr  <= sr >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == LAST) begin
                        // The holding register keeps OUT stable while the next operand shifts through res.
                        out_q  <= res_next;
                        ovf_q  <= msb_in & res_next[WIDTH-1];
                        zero_q <= (res_next == '0);
                        state  <= DONE;
                    end else if ((state == COPY) && sr[0]) begin
                        state  <= INVERT;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_serial_compliment2.sv
// Directed and table-driven checks of the 4-bit serial negator.
// The checks cover the serial stream, latency, flags, back-to-back operation, reset abort and a shuffled sweep.
module tb_serial_compliment2;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   passed = 0;
    int   total  = 0;
    int   done_cnt = 0;

    always #5 clk = ~clk;

    serial_compliment2_if #(.WIDTH(4)) bus ();

    serial_compliment2 #(.WIDTH(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.slave)
    );

    always @(negedge clk) if (bus.done === 1'b1) done_cnt++;

    typedef struct {
        logic [3:0] a;
        logic [3:0] out;
        logic       ovf;
        logic       zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) $display("FAIL %s: got %0h expected %0h", name, got, exp);
        else passed++;
    endtask

    // This task is entered at a negedge and returns at the negedge of the done cycle.
    task automatic run_vec(input vec_t v, input logic [3:0] prev_out);
        bus.start = 1'b1;
        bus.A     = v.a;
        @(negedge clk);
        bus.start = 1'b0;
        bus.A     = ~v.a;
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            check($sformatf("vec%h_valid%0d", v.a, k), bus.ser_valid, 1);
            check($sformatf("vec%h_bit%0d", v.a, k), bus.ser_out, v.out[k]);
            check($sformatf("vec%h_nodone%0d", v.a, k), bus.done, 0);
            if (k == 1) check($sformatf("vec%h_out_hold", v.a), bus.OUT, prev_out);
        end
        @(negedge clk);
        check($sformatf("vec%h_done", v.a), bus.done, 1);
        check($sformatf("vec%h_busy_off", v.a), bus.busy, 0);
        check($sformatf("vec%h_out", v.a), bus.OUT, v.out);
        check($sformatf("vec%h_ovf", v.a), bus.ovf, v.ovf);
        check($sformatf("vec%h_zero", v.a), bus.zero, v.zero);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] prev_out;
        logic [3:0] vals[16];
        logic       saw_done;
        int         dc0;

        vecs[0] = '{4'b0101, 4'b1011, 1'b0, 1'b0};
        vecs[1] = '{4'b0000, 4'b0000, 1'b0, 1'b1};
        vecs[2] = '{4'b1000, 4'b1000, 1'b1, 1'b0};
        vecs[3] = '{4'b0001, 4'b1111, 1'b0, 1'b0};
        vecs[4] = '{4'b0011, 4'b1101, 1'b0, 1'b0};
        vecs[5] = '{4'b1111, 4'b0001, 1'b0, 1'b0};
        vecs[6] = '{4'b0110, 4'b1010, 1'b0, 1'b0};
        vecs[7] = '{4'b1001, 4'b0111, 1'b0, 1'b0};

        bus.start = 1'b0;
        bus.A     = 4'h0;
        repeat (2) @(negedge clk);
        check("reset_busy", bus.busy, 0);
        check("reset_valid", bus.ser_valid, 0);
        check("reset_done", bus.done, 0);
        check("reset_out", bus.OUT, 0);
        check("reset_flags", {bus.ovf, bus.zero, bus.ser_out}, 0);
        rst_n = 1'b1;
        @(negedge clk);

        prev_out = 4'h0;
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], prev_out);
            prev_out = vecs[i].out;
            bus.start = 1'b0;
            @(negedge clk);
        end

        // Reset after two processed bits drops the conversion.
        bus.start = 1'b1;
        bus.A     = 4'b0101;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_before", bus.busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 0);
        check("abort_valid", bus.ser_valid, 0);
        check("abort_ser_out", bus.ser_out, 0);
        check("abort_done", bus.done, 0);
        check("abort_out", bus.OUT, 0);
        check("abort_flags", {bus.ovf, bus.zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            saw_done |= bus.done;
            check($sformatf("abort_idle%0d", i), bus.busy, 0);
        end
        check("abort_no_done", saw_done, 0);

        // Back-to-back: start stays high, and A changes while busy.
        bus.start = 1'b1;
        bus.A     = 4'b0011;
        @(negedge clk);
        bus.A     = 4'b1111;
        saw_done  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            saw_done |= bus.done;
        end
        check("b2b_first_nodone_early", saw_done, 0);
        @(negedge clk);
        check("b2b_first_done", bus.done, 1);
        check("b2b_first_out", bus.OUT, 4'b1101);
        saw_done = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            saw_done |= bus.done;
            check($sformatf("b2b_second_bit%0d", k), bus.ser_out, (4'b0001 >> k) & 1);
            if (k == 0) bus.start = 1'b0;
            if (k == 1) bus.start = 1'b1;
            if (k == 2) bus.start = 1'b0;
        end
        check("b2b_second_nodone_early", saw_done, 0);
        @(negedge clk);
        check("b2b_second_done", bus.done, 1);
        check("b2b_second_out", bus.OUT, 4'b0001);
        @(negedge clk);
        check("b2b_no_extra_accept", bus.busy, 0);

        // Shuffled sweep of all 16 operands with random idle gaps.
        for (int i = 0; i < 16; i++) vals[i] = 4'(i);
        for (int i = 15; i > 0; i--) begin
            int j;
            logic [3:0] t;
            j = $urandom_range(i, 0);
            t = vals[i];
            vals[i] = vals[j];
            vals[j] = t;
        end
        dc0 = done_cnt;
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            logic [3:0] e;
            int         iters;
            v = vals[i];
            e = 4'(~v + 4'd1);
            bus.start = 1'b1;
            bus.A     = v;
            @(negedge clk);
            bus.A = 4'($urandom);
            @(negedge clk);
            bus.start = 1'b0;
            iters = 0;
            while (iters < 12 && bus.done !== 1'b1) begin
                @(negedge clk);
                iters++;
            end
            check($sformatf("sweep%h_latency", v), iters, 3);
            check($sformatf("sweep%h_out", v), bus.OUT, e);
            check($sformatf("sweep%h_ovf", v), bus.ovf, v == 4'h8);
            check($sformatf("sweep%h_zero", v), bus.zero, v == 4'h0);
            repeat ($urandom_range(3, 0)) @(negedge clk);
        end
        repeat (3) @(negedge clk);
        #1;
        check("sweep_done_count", done_cnt - dc0, 16);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
